btn_debounce: RTL and testbench

// - Debounces the board's push-buttons (cursor up/down/left/right, select) for the game controller.
// - Sits downstream of the clock divider: it consumes the divider's slow output as a one-cycle sample strobe (tick_i).
// - It does not use that output as a clock. Everything runs on the single board clock clk_i.
// - Outputs a clean level per button plus a one-cycle press pulse that the game FSM consumes.

---
 rtl/btn_debounce.sv | 167 ++++++++++++++++
 tb/tb_btn_debounce.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus tick-sampled debounce FSM per button, giving a clean level and a press pulse.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat pulses while a button is held.
module btn_debounce #(
  parameter int N_BTN        = 5,
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 3,
  parameter int REPEAT_DLY   = 25,
  parameter int REPEAT_RATE  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o
);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_TICKS - 1);
  localparam bit               SINGLE_TICK = (STABLE_TICKS == 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DLY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DLY), 32'(REPEAT_RATE)};
`endif

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             press_q;
    logic             btn_s;

    assign btn_s = sync2_q[gi];
    assign cnt_d = cnt_q + CNT_W'(1);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             rpt_armed_q;
    logic             rpt_fire_d;

    // Before the first repeat the interval is REPEAT_DLY, afterwards REPEAT_RATE.
    assign rpt_cnt_d  = rpt_cnt_q + RPT_W'(1);
    assign rpt_fire_d = rpt_armed_q ? (rpt_cnt_d == RPT_NEXT) : (rpt_cnt_d == RPT_FIRST);
`endif

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q     <= REL;
        cnt_q       <= '0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rpt_cnt_q   <= '0;
        rpt_armed_q <= 1'b0;
`endif
      end else begin
        press_q <= 1'b0;
        if (tick_i) begin
          case (state_q)
            REL: begin
              if (btn_s) begin
                if (SINGLE_TICK) begin
                  state_q     <= PRS;
                  level_q     <= 1'b1;
                  press_q     <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                  rpt_cnt_q   <= '0;
                  rpt_armed_q <= 1'b0;
`endif
                end else begin
                  state_q <= REL_CHK;
                  cnt_q   <= CNT_W'(1);
                end
              end
            end
            REL_CHK: begin
              if (!btn_s) begin
                state_q <= REL;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_LAST) begin
                state_q     <= PRS;
                cnt_q       <= '0;
                level_q     <= 1'b1;
                press_q     <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                rpt_cnt_q   <= '0;
                rpt_armed_q <= 1'b0;
`endif
              end else begin
                cnt_q <= cnt_d;
              end
            end
            PRS: begin
              if (!btn_s) begin
                if (SINGLE_TICK) begin
                  state_q <= REL;
                  level_q <= 1'b0;
                end else begin
                  state_q <= PRS_CHK;
                  cnt_q   <= CNT_W'(1);
                end
              end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
              else if (rpt_fire_d) begin
                press_q     <= 1'b1;
                rpt_cnt_q   <= '0;
                rpt_armed_q <= 1'b1;
              end else begin
                rpt_cnt_q <= rpt_cnt_d;
              end
`endif
            end
            PRS_CHK: begin
              // Repeat counter is left untouched here so a bounce only pauses it.
              if (btn_s) begin
                state_q <= PRS;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_LAST) begin
                state_q <= REL;
                cnt_q   <= '0;
                level_q <= 1'b0;
              end else begin
                cnt_q <= cnt_d;
              end
            end
            default: begin
              state_q <= REL;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign btn_level_o[gi] = level_q;
    assign btn_press_o[gi] = press_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: tick every 4 clocks, press pulses checked against a cycle-stamped queue.
module tb_btn_debounce;
  localparam int N = 5;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RDLY  = 3;
  localparam int RRATE = 2;
`else
  localparam int RDLY  = 25;
  localparam int RRATE = 8;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         tick_i;
  logic [N-1:0] btn_i;
  logic [N-1:0] btn_level_o;
  logic [N-1:0] btn_press_o;

  typedef struct {
    int           cyc;
    logic [N-1:0] mask;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 1'b0;
  logic [N-1:0] zero   = '0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  btn_debounce #(
    .N_BTN       (N),
    .STABLE_TICKS(4),
    .CNT_W       (3),
    .REPEAT_DLY  (RDLY),
    .REPEAT_RATE (RRATE)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tick_i     (tick_i),
    .btn_i      (btn_i),
    .btn_level_o(btn_level_o),
    .btn_press_o(btn_press_o)
  );

  // One clock cycle; outputs are sampled 1ns after the edge and matched against the queue.
  task automatic step(input logic t);
    tick_i = t;
    @(posedge clk_i);
    #1;
    if (chk_en) begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        assert (btn_press_o === e.mask && cyc == e.cyc) else begin
          errors++;
          $error("FAIL press_pulse cyc=%0d observed=%b expected=%b (due cyc %0d)", cyc, btn_press_o, e.mask, e.cyc);
        end
      end else begin
        checks++;
        assert (btn_press_o === zero) else begin
          errors++;
          $error("FAIL no_press cyc=%0d observed=%b expected=%b", cyc, btn_press_o, zero);
        end
      end
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic expect_press(input int at, input logic [N-1:0] m);
    exp_t x;
    x.cyc  = at;
    x.mask = m;
    exp_q.push_back(x);
  endtask

  task automatic check_level(input string tag, input logic [N-1:0] want);
    checks++;
    assert (btn_level_o === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d level observed=%b expected=%b", tag, cyc, btn_level_o, want);
    end
  endtask

  initial begin
    int c;
    int r;
    rst_ni = 1'b0;
    tick_i = 1'b0;
    btn_i  = '0;
    repeat (3) step(1'b0);
    check_level("reset_level", 5'b00000);
    checks++;
    assert (btn_press_o === zero) else begin
      errors++;
      $error("FAIL reset_press observed=%b expected=%b", btn_press_o, zero);
    end
    rst_ni = 1'b1;
    chk_en = 1'b1;
    step(1'b0);

    // Clean press held for 10 ticks, then release.
    btn_i = 5'b00001;
    c = cyc;
    expect_press(c + 16, 5'b00001);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    expect_press(c + 28, 5'b00001);
    expect_press(c + 36, 5'b00001);
    expect_press(c + 44, 5'b00001);
    expect_press(c + 52, 5'b00001);
`endif
    run_ticks(3);
    check_level("t1_pre_accept", 5'b00000);
    run_ticks(1);
    check_level("t1_accept", 5'b00001);
    run_ticks(10);
    check_level("t1_held", 5'b00001);
    btn_i = '0;
    run_ticks(3);
    check_level("t1_release_pending", 5'b00001);
    run_ticks(1);
    check_level("t1_released", 5'b00000);

    // Two-tick glitch on button 1, then a real press.
    btn_i = 5'b00010;
    run_ticks(2);
    btn_i = '0;
    run_ticks(1);
    check_level("t2_glitch", 5'b00000);
    btn_i = 5'b00010;
    c = cyc;
    expect_press(c + 16, 5'b00010);
    run_ticks(3);
    check_level("t2_pre_accept", 5'b00000);
    run_ticks(1);
    check_level("t2_accept", 5'b00010);
    btn_i = '0;
    run_ticks(4);
    check_level("t2_released", 5'b00000);

    // Release bounce on button 2.
    btn_i = 5'b00100;
    c = cyc;
    expect_press(c + 16, 5'b00100);
    run_ticks(4);
    check_level("t3_accept", 5'b00100);
    for (int k = 0; k < 6; k++) begin
      btn_i = (k % 2 == 0) ? 5'b00000 : 5'b00100;
      run_ticks(1);
      check_level("t3_bounce", 5'b00100);
    end
    btn_i = '0;
    run_ticks(3);
    check_level("t3_release_pending", 5'b00100);
    run_ticks(1);
    check_level("t3_released", 5'b00000);

    // Coincident presses on buttons 0 and 4.
    btn_i = 5'b10001;
    c = cyc;
    expect_press(c + 16, 5'b10001);
    run_ticks(3);
    check_level("t4_pre_accept", 5'b00000);
    run_ticks(1);
    check_level("t4_accept", 5'b10001);
    btn_i = '0;
    run_ticks(4);
    check_level("t4_released", 5'b00000);

    // tick_i held high: 2 sync cycles then 4 samples.
    btn_i = 5'b00010;
    c = cyc;
    expect_press(c + 6, 5'b00010);
    repeat (5) step(1'b1);
    check_level("t5_pre_accept", 5'b00000);
    step(1'b1);
    check_level("t5_accept", 5'b00010);
    btn_i = '0;
    run_ticks(4);
    check_level("t5_released", 5'b00000);

    // Reset while button 3 is in REL_CHK with cnt=2 and button 0 is pressed.
    btn_i = 5'b00001;
    c = cyc;
    expect_press(c + 16, 5'b00001);
    run_ticks(4);
    check_level("t6_b0_accept", 5'b00001);
    btn_i = 5'b01001;
    run_ticks(2);
    check_level("t6_mid_debounce", 5'b00001);
    rst_ni = 1'b0;
    step(1'b0);
    rst_ni = 1'b1;
    r = cyc;
    check_level("t6_after_reset", 5'b00000);
    expect_press(r + 16, 5'b01001);
    run_ticks(3);
    check_level("t6_pre_reaccept", 5'b00000);
    run_ticks(1);
    check_level("t6_reaccept", 5'b01001);
    btn_i = '0;
    run_ticks(4);
    check_level("t6_released", 5'b00000);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_pulses observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
